// File: rtl/seg_reader.sv
// Two-digit seven-segment display reader: debounces {seg1,seg0}, decodes it and
// hands the result over a valid/ready port. Optional macro: SEG_READER_BLANK_EN.
`timescale 1ns/1ps

module seg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg0,
  input  logic [6:0] seg1,
  input  logic       ready,
  output logic       valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic       error,
  output logic [7:0] err_count
);

  // Handshake: a result is transferred on a rising edge where valid and ready
  // are both high; valid never drops and the result never changes before that.
  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PRESENT
  } state_t;

  state_t      state;
  logic [7:0]  count;
  logic [13:0] snapshot;
  logic [13:0] last_reported;
  logic [13:0] pair;

  logic [4:0]  dec_tens;
  logic [4:0]  dec_ones;
  logic        dec_ok;
  logic [6:0]  dec_value;
  logic        settle_done;

  assign pair = {seg1, seg0};

  // Returns {legal, digit}; an illegal pattern gives all zeros.
  function automatic logic [4:0] decode_digit(input logic [6:0] pat);
    case (pat)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    dec_tens = decode_digit(snapshot[13:7]);
    dec_ones = decode_digit(snapshot[6:0]);
`ifdef SEG_READER_BLANK_EN
    // A dark tens digit is leading-zero blanking, not a fault.
    if (snapshot[13:7] == 7'h00) begin
      dec_tens = {1'b1, 4'd0};
    end
`endif
    dec_ok    = dec_tens[4] & dec_ones[4];
    dec_value = 7'(dec_tens[3:0]) * 7'd10 + 7'(dec_ones[3:0]);
  end

  // The edge that brings count up to STABLE_CYCLES completes the settle.
  assign settle_done = (count == 8'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= 8'd0;
      snapshot      <= 14'd0;
      last_reported <= 14'd0;
      valid         <= 1'b0;
      tens          <= 4'd0;
      ones          <= 4'd0;
      value         <= 7'd0;
      error         <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pair != last_reported) begin
            snapshot <= pair;
            count    <= 8'd1;
            state    <= SETTLE;
          end
        end

        SETTLE: begin
          if (pair != snapshot) begin
            snapshot <= pair;
            count    <= 8'd1;
          end else begin
            count <= count + 8'd1;
            if (settle_done) begin
              valid <= 1'b1;
              state <= PRESENT;
              if (dec_ok) begin
                tens  <= dec_tens[3:0];
                ones  <= dec_ones[3:0];
                value <= dec_value;
                error <= 1'b0;
              end else begin
                tens  <= 4'd0;
                ones  <= 4'd0;
                value <= 7'd0;
                error <= 1'b1;
              end
            end
          end
        end

        PRESENT: begin
          // Inputs are ignored here; the snapshot is what gets remembered.
          if (ready) begin
            last_reported <= snapshot;
            valid         <= 1'b0;
            state         <= IDLE;
            if (error && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares on every accepted result.
`timescale 1ns/1ps

module tb_seg_reader;

  localparam int STABLE = 4;
  localparam int W      = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg0  = 7'h00;
  logic [6:0] seg1  = 7'h00;
  logic       ready = 1'b0;
  logic       valid;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] value;
  logic       error;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  seg_reader #(.STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg0      (seg0),
    .seg1      (seg1),
    .ready     (ready),
    .valid     (valid),
    .tens      (tens),
    .ones      (ones),
    .value     (value),
    .error     (error),
    .err_count (err_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: one pop per accepted result
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      checks++;
      popped++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected result error=%0d tens=%0d ones=%0d value=%0d",
                 error, tens, ones, value);
      end else begin
        exp_v = exp_q.pop_front();
        if ({error, tens, ones, value} !== exp_v) begin
          errors++;
          $display("FAIL result: got error=%0d tens=%0d ones=%0d value=%0d, expected error=%0d tens=%0d ones=%0d value=%0d",
                   error, tens, ones, value, exp_v[15], exp_v[14:11], exp_v[10:7], exp_v[6:0]);
        end
      end
    end
  end

  // Driver and check tasks
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic e, input logic [3:0] t, input logic [3:0] o,
                          input logic [6:0] v);
    exp_q.push_back({e, t, o, v});
    pushed++;
  endtask

  task automatic set_pair(input logic [6:0] s1, input logic [6:0] s0);
    @(posedge clk);
    #1;
    seg1 = s1;
    seg0 = s0;
  endtask

  // Called just after an edge with the new pair applied; valid must rise
  // exactly after the STABLE-th following edge.
  task automatic settle_check(input string name);
    for (int i = 1; i <= STABLE; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < STABLE) chk({name, "_early"}, int'(valid), 0);
      else            chk({name, "_valid"}, int'(valid), 1);
    end
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    logic [6:0] s0;

    // Reset values
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_tens", int'(tens), 0);
    chk("rst_ones", int'(ones), 0);
    chk("rst_value", int'(value), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_count", int'(err_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Blank display equals last_reported after reset: nothing reported
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("blank_idle", int'(valid), 0);
    end

    // Stable decode 35
    set_pair(7'h4F, 7'h6D);
    settle_check("stable_35");
    push_exp(1'b0, 4'd3, 4'd5, 7'd35);
    accept();
    @(negedge clk);
    chk("stable_35_drop", int'(valid), 0);

    // Unchanged display with ready held: no re-report, no effect
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_rereport", int'(valid), 0);
    end
    @(posedge clk);
    #1;
    ready = 1'b0;

    // Glitching ones digit then stable 5B
    set_pair(7'h06, 7'h06);
    set_pair(7'h06, 7'h5B);
    set_pair(7'h06, 7'h06);
    set_pair(7'h06, 7'h5B);
    settle_check("glitch_12");
    push_exp(1'b0, 4'd1, 4'd2, 7'd12);
    accept();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("glitch_once", int'(valid), 0);
    end

    // Invalid digit and err_count saturation
    set_pair(7'h06, 7'h01);
    settle_check("invalid");
    push_exp(1'b1, 4'd0, 4'd0, 7'd0);
    accept();
    @(negedge clk);
    chk("err_count_1", int'(err_count), 1);
    for (int i = 1; i <= 255; i++) begin
      s0 = (i % 2 == 1) ? 7'h02 : 7'h01;
      set_pair(7'h06, s0);
      settle_check("invalid_loop");
      push_exp(1'b1, 4'd0, 4'd0, 7'd0);
      accept();
      if (i == 1) begin
        @(negedge clk);
        chk("err_count_2", int'(err_count), 2);
      end
      if (i >= 254) begin
        @(negedge clk);
        chk("err_count_sat", int'(err_count), 255);
      end
    end

    // Backpressure: result 24 frozen while inputs move to 88
    set_pair(7'h5B, 7'h66);
    settle_check("bp_24");
    push_exp(1'b0, 4'd2, 4'd4, 7'd24);
    set_pair(7'h7F, 7'h7F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(valid), 1);
      chk("bp_hold_value", int'(value), 24);
    end
    accept();
    settle_check("bp_88");
    push_exp(1'b0, 4'd8, 4'd8, 7'd88);
    accept();

    // Blank tens digit
    set_pair(7'h00, 7'h7D);
    settle_check("blank_tens");
`ifdef SEG_READER_BLANK_EN
    push_exp(1'b0, 4'd0, 4'd6, 7'd6);
`else
    push_exp(1'b1, 4'd0, 4'd0, 7'd0);
`endif
    accept();
    @(negedge clk);
    chk("blank_err_count", int'(err_count), 255);

    // Reset while presenting 97, then re-report after release
    set_pair(7'h6F, 7'h07);
    settle_check("pre_reset_97");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_value", int'(value), 0);
    chk("async_rst_err_count", int'(err_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle_check("post_reset_97");
    push_exp(1'b0, 4'd9, 4'd7, 7'd97);
    accept();
    @(negedge clk);
    chk("post_reset_err_count", int'(err_count), 0);

    // Final report
    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("results_popped", popped, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_reader.md
SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical samples required before a pattern is accepted; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: seg0  input  7  ones-digit segments {g,f,e,d,c,b,a}, active-high.
REQ-005 Port: seg1  input  7  tens-digit segments, same encoding.
REQ-006 Port: ready  input  1  consumer accepts the presented result.
REQ-007 Port: valid  output  1  result presented; held until accepted.
REQ-008 Port: tens  output  4  decoded tens digit.
REQ-009 Port: ones  output  4  decoded ones digit.
REQ-010 Port: value  output  7  tens*10+ones, unsigned binary, 0..99.
REQ-011 Port: error  output  1  presented pattern pair contained an undecodable digit.
REQ-012 Port: err_count  output  8  count of accepted error results, saturating at 255.

Function
REQ-013 Legal digit patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); any other pattern is invalid.
REQ-014 FSM states: IDLE, SETTLE, PRESENT.
REQ-015 IDLE: if {seg1,seg0} differs from last_reported, snapshot it, set count=1, go to SETTLE; otherwise remain.
REQ-016 SETTLE: on mismatch with the snapshot, re-snapshot and reset count=1, staying in SETTLE; on a match, increment count.
REQ-017 SETTLE exit: on the edge where a match brings count to STABLE_CYCLES, load the outputs, set valid=1, and go to PRESENT.
REQ-018 Latency: valid is high immediately after the STABLE_CYCLES-th consecutive edge sampling the same new pair; minimum latency is STABLE_CYCLES cycles.
REQ-019 PRESENT: valid, tens, ones, value and error remain constant; input changes are ignored.
REQ-020 Handshake: on an edge with valid&ready, set last_reported=snapshot, valid=0, go to IDLE; if error=1, also increment err_count (saturating).
REQ-021 A pair that changes and returns to last_reported before acceptance is reported once stable, since IDLE compares only at entry.
REQ-022 In IDLE, a pair equal to last_reported produces no result, so an unchanged display is never re-reported.
REQ-023 Error result: if either digit is invalid, error=1 and tens=ones=value=0.
REQ-024 Valid result: error=0; tens, ones and value per REQ-013 and REQ-010.
REQ-025 ready while not valid has no effect.
REQ-026 Back-to-back: a new pair already present at handshake enters SETTLE on the first IDLE edge after acceptance.

Reset
REQ-027 On rst_n=0, state=IDLE, valid=0, tens=0, ones=0, value=0, error=0, err_count=0, count=0, snapshot=0, last_reported={7'h00,7'h00}, all immediately and asynchronously.
REQ-028 Reset during SETTLE or PRESENT discards the pending result; no handshake or err_count update occurs.
REQ-029 After rst_n deasserts, any non-blank pair is reported once stable.

Configuration
REQ-030 Macro SEG_READER_BLANK_EN.
REQ-031 Defined: seg1=00 (blank) decodes as tens=0 (leading-zero blanking); seg0=00 remains invalid.
REQ-032 Not defined: seg1=00 is invalid and yields error=1.

Verification
REQ-033 Stable decode: seg1=4F, seg0=6D held 4 cycles -> valid after 4th edge, tens=3, ones=5, value=35, error=0; ready=1 -> valid=0 next edge.
REQ-034 Glitch restart: seg0 alternates 06/5B for 3 cycles, then holds 5B for 4 cycles -> exactly one result, ones=2, valid at 4th stable edge.
REQ-035 Invalid digit: seg1=06, seg0=01 stable, then ready -> error=1, value=0, err_count 0->1; 256 such results -> err_count=255.
REQ-036 Backpressure: ready=0 for 10 cycles while inputs change to 7F/7F -> outputs frozen at first result; after ready, 88 reported.
REQ-037 Blank tens: seg1=00, seg0=7D -> value=6, error=0 with SEG_READER_BLANK_EN defined; error=1 without it.
REQ-038 Reset in PRESENT: rst_n=0 mid-cycle -> valid, value and err_count go to 0 before the next edge; the same inputs are re-reported after release.
